// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive and transmit halves.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int OVERSAMPLE     = 8;
    localparam int PRESCALE_CNT_W = 19;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input; resets to 1 (idle-high lines).
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8x-oversampled async serial line to AXI4-Stream words.
// Optional parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    input  logic [15:0]           prescale
`ifdef UART_RX_PARITY_EN
    ,
    input  logic                  parity_odd,
    output logic                  parity_error
`endif
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);

    uart_state_t               r_state, w_state_next;
    logic [PRESCALE_CNT_W-1:0] r_cnt, w_cnt_next;
    logic [BIT_CNT_W-1:0]      r_bit_cnt, w_bit_cnt_next;
    logic [DATA_WIDTH-1:0]     r_shift, w_shift_next;
    logic [15:0]               r_prescale, w_prescale_next;
    logic                      r_armed, w_armed_next;
    logic                      r_busy;
    logic [DATA_WIDTH-1:0]     r_tdata;
    logic                      r_tvalid;
    logic                      r_overrun;
    logic                      r_frame_err;
    logic                      w_rxd_s;
    logic                      w_cnt_zero;
    logic                      w_word_done;
    logic                      w_frame_err;
    logic [PRESCALE_CNT_W-1:0] w_half_load;
    logic [PRESCALE_CNT_W-1:0] w_bit_load;
`ifdef UART_RX_PARITY_EN
    logic                      r_par_bad, w_par_bad_next;
    logic                      r_par_err;
`endif

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rxd),
        .o_q   (w_rxd_s)
    );

    // Half a bit uses the live prescale (latched in the same cycle); full bits use the latched copy.
    assign w_half_load = {1'b0, prescale, 2'b00} - PRESCALE_CNT_W'(1);
    assign w_bit_load  = {r_prescale, 3'b000} - PRESCALE_CNT_W'(1);
    assign w_cnt_zero  = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_prescale <= '0;
            r_armed    <= 1'b1;
            r_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift    <= w_shift_next;
            r_prescale <= w_prescale_next;
            r_armed    <= w_armed_next;
            r_busy     <= (w_state_next != IDLE);
`ifdef UART_RX_PARITY_EN
            r_par_bad  <= w_par_bad_next;
`endif
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_bit_cnt_next  = r_bit_cnt;
        w_shift_next    = r_shift;
        w_prescale_next = r_prescale;
        w_armed_next    = r_armed;
        w_word_done     = 1'b0;
        w_frame_err     = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_next  = r_par_bad;
`endif
        case (r_state)
            IDLE: begin
                if (w_rxd_s) begin
                    w_armed_next = 1'b1;
                end else if (r_armed && (prescale != '0)) begin
                    w_cnt_next      = w_half_load;
                    w_prescale_next = prescale;
                    w_state_next    = START;
                end
            end
            START: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - PRESCALE_CNT_W'(1);
                end else if (!w_rxd_s) begin
                    w_cnt_next     = w_bit_load;
                    w_bit_cnt_next = BIT_CNT_W'(DATA_WIDTH);
                    w_state_next   = DATA;
                end else begin
                    w_state_next = IDLE;
                end
            end
            DATA: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - PRESCALE_CNT_W'(1);
                end else begin
                    w_shift_next   = {w_rxd_s, r_shift[DATA_WIDTH-1:1]};
                    w_bit_cnt_next = r_bit_cnt - BIT_CNT_W'(1);
                    w_cnt_next     = w_bit_load;
                    if (r_bit_cnt == BIT_CNT_W'(1)) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - PRESCALE_CNT_W'(1);
                end else begin
                    w_par_bad_next = w_rxd_s ^ (^r_shift) ^ parity_odd;
                    w_cnt_next     = w_bit_load;
                    w_state_next   = STOP;
                end
            end
`endif
            STOP: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - PRESCALE_CNT_W'(1);
                end else begin
                    w_state_next = IDLE;
                    if (w_rxd_s) begin
                        w_word_done = 1'b1;
                    end else begin
                        w_frame_err  = 1'b1;
                        w_armed_next = 1'b0;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // A new word with the old one still pending and not accepted this cycle replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err   <= 1'b0;
`endif
        end else begin
            r_overrun   <= 1'b0;
            r_frame_err <= w_frame_err;
`ifdef UART_RX_PARITY_EN
            r_par_err   <= w_word_done && r_par_bad;
`endif
            if (r_tvalid && m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
            if (w_word_done) begin
                r_tdata   <= r_shift;
                r_tvalid  <= 1'b1;
                r_overrun <= r_tvalid && !m_axis_tready;
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign busy          = r_busy;
    assign overrun_error = r_overrun;
    assign frame_error   = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = r_par_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected words queued at send time, popped on each handshake.
module tb_uart_rx;

    logic        clk;
    logic        rst_n;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        rxd;
    logic        busy;
    logic        overrun_error;
    logic        frame_error;
    logic [15:0] prescale;
`ifdef UART_RX_PARITY_EN
    logic        parity_odd;
    logic        parity_error;
`endif

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .rxd           (rxd),
        .busy          (busy),
        .overrun_error (overrun_error),
        .frame_error   (frame_error),
        .prescale      (prescale)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_odd    (parity_odd),
        .parity_error  (parity_error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_words = 0;
    int         n_ovr   = 0;
    int         n_fe    = 0;
    int         n_busy  = 0;
    int         n_par   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        n_words = 0;
        n_ovr   = 0;
        n_fe    = 0;
        n_busy  = 0;
        n_par   = 0;
    endtask

    task automatic hold(input logic b, input int clks);
        rxd = b;
        repeat (clks) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
        int bc;
        bc = int'(prescale) * 8;
        hold(1'b0, bc);
        for (int i = 0; i < 8; i++) hold(d[i], bc);
`ifdef UART_RX_PARITY_EN
        hold((^d) ^ parity_odd ^ bad_par, bc);
`endif
        hold(stop_bit, bc);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_axis_tvalid && m_axis_tready) begin
                n_words++;
                if (exp_q.size() == 0) check("unexpected_word", 32'(m_axis_tdata), 32'hffff_ffff);
                else check("tdata", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
            end
            if (overrun_error) n_ovr++;
            if (frame_error)   n_fe++;
            if (busy)          n_busy++;
`ifdef UART_RX_PARITY_EN
            if (parity_error)  n_par++;
`endif
        end
    end

    initial begin
        rst_n         = 1'b0;
        rxd           = 1'b1;
        m_axis_tready = 1'b0;
        prescale      = 16'd1;
`ifdef UART_RX_PARITY_EN
        parity_odd    = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 32'(m_axis_tvalid), 0);
        check("rst_tdata",  32'(m_axis_tdata), 0);
        check("rst_busy",   32'(busy), 0);
        check("rst_ovr",    32'(overrun_error), 0);
        check("rst_fe",     32'(frame_error), 0);
        rst_n = 1'b1;
        hold(1'b1, 5);

        // Back-to-back frames at 8 clocks per bit
        clr_counts();
        m_axis_tready = 1'b1;
        prescale      = 16'd1;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hA3);
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b0);
        hold(1'b1, 10);
        check("b2b_words", n_words, 2);
        check("b2b_ovr",   n_ovr, 0);
        check("b2b_fe",    n_fe, 0);
        check("b2b_drain", exp_q.size(), 0);

        // Overrun: second word replaces the unread first one
        clr_counts();
        m_axis_tready = 1'b0;
        prescale      = 16'd4;
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        hold(1'b1, 10);
        check("ovr_count",  n_ovr, 1);
        check("ovr_tvalid", 32'(m_axis_tvalid), 1);
        check("ovr_tdata",  32'(m_axis_tdata), 32'h22);
        m_axis_tready = 1'b1;
        hold(1'b1, 5);
        check("ovr_words",  n_words, 1);
        check("ovr_tvalid_clr", 32'(m_axis_tvalid), 0);
        check("ovr_drain",  exp_q.size(), 0);

        // Frame error, then a stuck-low line must not retrigger
        clr_counts();
        prescale = 16'd2;
        send_frame(8'h3C, 1'b0, 1'b0);
        hold(1'b0, 100);
        check("fe_count",  n_fe, 1);
        check("fe_words",  n_words, 0);
        check("fe_tvalid", 32'(m_axis_tvalid), 0);
        check("fe_busy_low", 32'(busy), 0);
        hold(1'b1, 20);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 1'b0);
        hold(1'b1, 10);
        check("fe_next_words", n_words, 1);
        check("fe_next_fe",    n_fe, 1);
        check("fe_drain",      exp_q.size(), 0);

        // Short glitch on an idle line is rejected at mid start bit
        clr_counts();
        prescale = 16'd2;
        hold(1'b0, 3);
        hold(1'b1, 40);
        check("glitch_busy", 32'(n_busy >= 6 && n_busy <= 10), 1);
        check("glitch_words", n_words, 0);
        check("glitch_fe",    n_fe, 0);
        check("glitch_ovr",   n_ovr, 0);

        // prescale of zero keeps the receiver idle
        clr_counts();
        prescale = 16'd0;
        hold(1'b0, 40);
        check("p0_busy", n_busy, 0);
        hold(1'b1, 10);
        check("p0_words", n_words, 0);

        // Reset during bit 4 of 0xF0 aborts the frame cleanly
        clr_counts();
        prescale = 16'd8;
        hold(1'b0, 64);
        for (int i = 0; i < 4; i++) hold(1'b0, 64);
        hold(1'b1, 20);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", 32'(m_axis_tvalid), 0);
        check("mid_rst_tdata",  32'(m_axis_tdata), 0);
        check("mid_rst_busy",   32'(busy), 0);
        check("mid_rst_ovr",    32'(overrun_error), 0);
        check("mid_rst_fe",     32'(frame_error), 0);
        hold(1'b1, 5);
        rst_n = 1'b1;
        hold(1'b1, 10);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, 1'b0);
        hold(1'b1, 10);
        check("post_rst_words", n_words, 1);
        check("post_rst_fe",    n_fe, 0);
        check("post_rst_drain", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
        // Even parity, wrong parity bit: word delivered and parity_error pulses
        clr_counts();
        parity_odd = 1'b0;
        prescale   = 16'd2;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        hold(1'b1, 10);
        check("par_words", n_words, 1);
        check("par_err",   n_par, 1);
        clr_counts();
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        hold(1'b1, 10);
        check("par_ok_words", n_words, 1);
        check("par_ok_err",   n_par, 0);
        check("par_drain",    exp_q.size(), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
